rx_4b: RTL and testbench
========================

Name: rx_4b

Overview:
- SPI receive stage for the 4-bit ALU datapath; the write-direction counterpart of the 4-bit transmit stage.
- Samples 4-bit MOSI nibbles on SPI clock rising edges, oversampled in the system clock domain.
- Assembles each fixed-length frame into two operands plus an opcode.
- Presents the assembled instruction to the ALU over a valid/ready handshake, with one-deep output buffering.

Parameters:
- OP_W, 8, operand width in bits; must be a multiple of 4. Nibbles per operand NPO = OP_W/4.
- FRAME_N (derived, not overridable), 2*NPO+1, data nibbles per frame (5 at default).

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- spi_clk  input  1  SPI clock, sampled in the clk domain
- spi_w  input  1  SPI write enable; frame window
- mosi  input  4  MOSI nibble
- op_a  output  OP_W  operand A
- op_b  output  OP_W  operand B
- opcode  output  4  ALU opcode
- instr_valid  output  1  instruction available to ALU
- instr_ready  input  1  ALU accepts instruction
- rx_busy  output  1  frame in progress (state RECV)
- rx_done  output  1  1-cycle pulse: frame loaded into output register
- rx_overrun  output  1  1-cycle pulse: completed frame dropped because output was full
- rx_chk_err  output  1  1-cycle pulse: checksum mismatch (tied 0 without RX_CHECKSUM_EN)

Behaviour:
- Reset and clocking:
  - All state changes on posedge clk.
  - With rst_n=0 at an edge: state=IDLE, nibble counter=0, spi_clk_prev=0, shift registers=0.
  - Output reset values: op_a/op_b/opcode=0, instr_valid=0, rx_busy=0, rx_done=0, rx_overrun=0, rx_chk_err=0.
  - Reset mid-frame discards the partial frame and any pending instruction.
- Edge detect: spi_clk_prev <= spi_clk every cycle. rise = spi_clk & ~spi_clk_prev. mosi is captured in the same clk cycle that rise is true.
- Frame nibble order (LS nibble first):
  - op_a nibbles 0..NPO-1
  - op_b nibbles 0..NPO-1
  - opcode
  - Default frame: A[3:0], A[7:4], B[3:0], B[7:4], opcode.
- State machine:
  - IDLE → RECV on the cycle spi_w=1. A rise in that same cycle is captured as nibble 0.
  - RECV, spi_w=1 & rise: store nibble at counter position. If counter < FRAME_N-1, increment; otherwise do completion handling and go to IDLE-ARMED.
  - RECV, spi_w=0 (any cycle): abort. Partial frame discarded, counter=0, → IDLE, no pulses.
  - IDLE-ARMED: waits for spi_w=0 → IDLE. Further rises while spi_w stays 1 are ignored, so one frame per spi_w window.
  - rx_busy=1 only in RECV.
- Completion handling (registered at the final-nibble edge; outputs visible the next cycle):
  - Output register free, or freed this cycle (instr_valid=1 & instr_ready=1): load op_a/op_b/opcode, instr_valid=1, rx_done pulse.
  - Otherwise: frame dropped, outputs unchanged, rx_overrun pulse.
- Handshake:
  - Transfer occurs when instr_valid & instr_ready.
  - With no simultaneous load, instr_valid clears the next cycle.
  - While valid, op_a/op_b/opcode are stable until transfer.
  - instr_ready is ignored while instr_valid=0.
- Simultaneous transfer and frame completion: new frame is loaded, instr_valid stays 1, rx_done pulses, no overrun.
- Counter: 0..FRAME_N-1, never wraps inside a frame; reset to 0 on leaving RECV.

Optional Feature:
- Macro: RX_CHECKSUM_EN.
- Defined:
  - Frame gains a trailing nibble (FRAME_N+1 total) holding the XOR of all data nibbles.
  - On mismatch: frame discarded, rx_chk_err pulses, no rx_done, no rx_overrun, output register unchanged.
  - On match: normal completion handling.
- Undefined: no checksum nibble, rx_chk_err constant 0.

Test Plan:
- Reset, then frame 5,A,3,C,2 (A=0xA5, B=0xC3, op=2), instr_ready=1 → one cycle after the 5th rise: instr_valid=1, op_a=0xA5, op_b=0xC3, opcode=2, rx_done single pulse; valid clears next cycle.
- instr_ready=0: frame1 (A=0x11, B=0x22, op=1), then frame2 (A=0x33, B=0x44, op=3) → outputs hold 0x11/0x22/1, rx_overrun pulses once at frame2 completion; after ready=1, valid drops and no frame2 data appears.
- spi_w dropped after 3 nibbles, then full frame A=0x0F, B=0xF0, op=4 → only the second frame is delivered, no pulse from the aborted one, rx_busy low between frames.
- instr_ready asserted in the exact cycle the next frame completes → instr_valid remains 1, new operands present, rx_done=1, rx_overrun=0.
- rst_n=0 for one edge after 2 nibbles with valid pending → all outputs 0 next cycle; following frame A=0x5A, B=0x01, op=7 received correctly from nibble 0.
- RX_CHECKSUM_EN: frame 1,2,3,4,5 + chk 1 → delivered; + chk 0 → rx_chk_err pulse, instr_valid stays 0.

Source files
------------

// File: rtl/rx_4b.sv
// SPI receive stage for the 4-bit ALU datapath: assembles LS-nibble-first frames
// (op_a, op_b, opcode) into a one-deep valid/ready output register.
// Optional trailing XOR checksum nibble is enabled with `define RX_CHECKSUM_EN.
module rx_4b #(
    parameter int OP_W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            spi_clk,
    input  logic            spi_w,
    input  logic [3:0]      mosi,
    output logic [OP_W-1:0] op_a,
    output logic [OP_W-1:0] op_b,
    output logic [3:0]      opcode,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic            rx_busy,
    output logic            rx_done,
    output logic            rx_overrun,
    output logic            rx_chk_err
);

    localparam int NPO     = OP_W / 4;
    localparam int FRAME_N = 2 * NPO + 1;
`ifdef RX_CHECKSUM_EN
    localparam int FRAME_T = FRAME_N + 1;
`else
    localparam int FRAME_T = FRAME_N;
`endif
    localparam int               CNT_W    = $clog2(FRAME_T);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_T - 1);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        ARMED
    } state_t;

    state_t                      state_q, state_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        spi_clk_prev;
    logic [FRAME_T-1:0][3:0]     frame_q, frame_d;

    logic                        rise;
    logic                        capture;
    logic                        last;
    logic                        chk_ok;
    logic                        out_free;
    logic                        load;
    logic                        overrun;
    logic                        valid_d;
    logic [OP_W-1:0]             op_a_d;
    logic [OP_W-1:0]             op_b_d;
    logic [3:0]                  opcode_d;

    assign rise    = spi_clk & ~spi_clk_prev;
    assign rx_busy = (state_q == RECV);

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        frame_d = frame_q;
        capture = 1'b0;
        last    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (spi_w) begin
                    state_d = RECV;
                    capture = rise;
                end
            end
            RECV: begin
                if (!spi_w) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    capture = rise;
                end
            end
            ARMED: begin
                if (!spi_w) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // The counter is 0 in IDLE, so a rise coinciding with spi_w going high
        // lands in nibble 0 and can never be the final nibble.
        if (capture) begin
            frame_d[cnt_q] = mosi;
            if (cnt_q == CNT_LAST) begin
                last    = 1'b1;
                cnt_d   = '0;
                state_d = ARMED;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign op_a_d   = frame_d[NPO-1:0];
    assign op_b_d   = frame_d[2*NPO-1:NPO];
    assign opcode_d = frame_d[2*NPO];

`ifdef RX_CHECKSUM_EN
    logic [3:0] chk_calc;
    always_comb begin
        chk_calc = '0;
        for (int i = 0; i < FRAME_N; i++) chk_calc = chk_calc ^ frame_d[i];
    end
    assign chk_ok = (chk_calc == frame_d[FRAME_N]);
`else
    assign chk_ok = 1'b1;
`endif

    // A transfer in the completion cycle frees the register for the new frame.
    assign out_free = ~instr_valid | instr_ready;
    assign load     = last & chk_ok & out_free;
    assign overrun  = last & chk_ok & ~out_free;

    always_comb begin
        valid_d = instr_valid;
        if (load)                            valid_d = 1'b1;
        else if (instr_valid && instr_ready) valid_d = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            spi_clk_prev <= 1'b0;
            // NOTE: the nibble store is a plain register array, not RAM, so it
            // is cleared here together with the rest of the state.
            frame_q      <= '0;
            op_a         <= '0;
            op_b         <= '0;
            opcode       <= '0;
            instr_valid  <= 1'b0;
            rx_done      <= 1'b0;
            rx_overrun   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            spi_clk_prev <= spi_clk;
            frame_q      <= frame_d;
            instr_valid  <= valid_d;
            rx_done      <= load;
            rx_overrun   <= overrun;
            if (load) begin
                op_a   <= op_a_d;
                op_b   <= op_b_d;
                opcode <= opcode_d;
            end
        end
    end

`ifdef RX_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!rst_n) rx_chk_err <= 1'b0;
        else        rx_chk_err <= last & ~chk_ok;
    end
`else
    assign rx_chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_rx_4b.sv
// Directed self-checking bench for rx_4b at the default OP_W=8.
// Build with RX_CHECKSUM_EN defined to also exercise the checksum nibble.
module tb_rx_4b;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       spi_clk;
    logic       spi_w;
    logic [3:0] mosi;
    logic [7:0] op_a;
    logic [7:0] op_b;
    logic [3:0] opcode;
    logic       instr_valid;
    logic       instr_ready;
    logic       rx_busy;
    logic       rx_done;
    logic       rx_overrun;
    logic       rx_chk_err;

    int n_checks = 0;
    int n_errors = 0;

    rx_4b #(.OP_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .spi_clk     (spi_clk),
        .spi_w       (spi_w),
        .mosi        (mosi),
        .op_a        (op_a),
        .op_b        (op_b),
        .opcode      (opcode),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .rx_busy     (rx_busy),
        .rx_done     (rx_done),
        .rx_overrun  (rx_overrun),
        .rx_chk_err  (rx_chk_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Outputs are sampled 1 ns after the edge, inputs change there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Rising SPI clock with a nibble; returns just after the capturing edge.
    task automatic rise_nib(input logic [3:0] n);
        spi_clk = 1'b1;
        mosi    = n;
        tick();
        spi_clk = 1'b0;
    endtask

    task automatic nib(input logic [3:0] n);
        rise_nib(n);
        tick();
    endtask

    // Opens the spi_w window and sends one frame; returns right after the
    // final-nibble edge so completion outputs can be checked.
    task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                              input logic ready_last, input logic bad_chk);
        spi_w = 1'b1;
        tick();
        nib(a[3:0]);
        nib(a[7:4]);
        nib(b[3:0]);
        nib(b[7:4]);
`ifdef RX_CHECKSUM_EN
        nib(op);
        if (ready_last) instr_ready = 1'b1;
        rise_nib(a[3:0] ^ a[7:4] ^ b[3:0] ^ b[7:4] ^ op ^ {3'b000, bad_chk});
`else
        if (ready_last) instr_ready = 1'b1;
        rise_nib(op);
`endif
    endtask

    task automatic end_window();
        spi_w = 1'b0;
        tick();
    endtask

    initial begin
        rst_n       = 1'b0;
        spi_clk     = 1'b0;
        spi_w       = 1'b0;
        mosi        = 4'h0;
        instr_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_valid",   instr_valid, 0);
        check("rst_op_a",    op_a, 0);
        check("rst_op_b",    op_b, 0);
        check("rst_opcode",  opcode, 0);
        check("rst_busy",    rx_busy, 0);
        check("rst_done",    rx_done, 0);
        check("rst_overrun", rx_overrun, 0);
        check("rst_chk_err", rx_chk_err, 0);

        // Basic frame with the ALU ready.
        instr_ready = 1'b1;
        send_frame(8'hA5, 8'hC3, 4'h2, 1'b0, 1'b0);
        check("t1_valid",   instr_valid, 1);
        check("t1_op_a",    op_a, 8'hA5);
        check("t1_op_b",    op_b, 8'hC3);
        check("t1_opcode",  opcode, 4'h2);
        check("t1_done",    rx_done, 1);
        check("t1_overrun", rx_overrun, 0);
        check("t1_chk_err", rx_chk_err, 0);
        check("t1_busy",    rx_busy, 0);
        end_window();
        check("t1_valid_clr", instr_valid, 0);
        check("t1_done_clr",  rx_done, 0);

        // Overrun: second frame arrives while the first is still pending.
        instr_ready = 1'b0;
        send_frame(8'h11, 8'h22, 4'h1, 1'b0, 1'b0);
        check("t2_f1_done",  rx_done, 1);
        check("t2_f1_valid", instr_valid, 1);
        end_window();
        send_frame(8'h33, 8'h44, 4'h3, 1'b0, 1'b0);
        check("t2_overrun", rx_overrun, 1);
        check("t2_done",    rx_done, 0);
        check("t2_op_a",    op_a, 8'h11);
        check("t2_op_b",    op_b, 8'h22);
        check("t2_opcode",  opcode, 4'h1);
        check("t2_valid",   instr_valid, 1);
        end_window();
        check("t2_overrun_pulse", rx_overrun, 0);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        check("t2_valid_clr", instr_valid, 0);
        check("t2_op_a_keep", op_a, 8'h11);
        tick();
        check("t2_no_f2", instr_valid, 0);

        // Aborted partial frame followed by a complete one.
        spi_w = 1'b1;
        tick();
        nib(4'h1);
        nib(4'h2);
        check("t3_busy_mid", rx_busy, 1);
        nib(4'h3);
        spi_w = 1'b0;
        tick();
        check("t3_abort_busy",  rx_busy, 0);
        check("t3_abort_done",  rx_done, 0);
        check("t3_abort_valid", instr_valid, 0);
        tick();
        check("t3_abort_ovr", rx_overrun, 0);
        send_frame(8'h0F, 8'hF0, 4'h4, 1'b0, 1'b0);
        check("t3_op_a",   op_a, 8'h0F);
        check("t3_op_b",   op_b, 8'hF0);
        check("t3_opcode", opcode, 4'h4);
        check("t3_done",   rx_done, 1);
        end_window();

        // Transfer in the same cycle the next frame completes.
        send_frame(8'h12, 8'h34, 4'h5, 1'b1, 1'b0);
        instr_ready = 1'b0;
        check("t4_valid",   instr_valid, 1);
        check("t4_op_a",    op_a, 8'h12);
        check("t4_op_b",    op_b, 8'h34);
        check("t4_opcode",  opcode, 4'h5);
        check("t4_done",    rx_done, 1);
        check("t4_overrun", rx_overrun, 0);
        end_window();
        check("t4_valid_hold", instr_valid, 1);

        // Reset mid-frame with an instruction pending.
        spi_w = 1'b1;
        tick();
        nib(4'h9);
        nib(4'h6);
        rst_n = 1'b0;
        spi_w = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t5_valid",  instr_valid, 0);
        check("t5_op_a",   op_a, 0);
        check("t5_op_b",   op_b, 0);
        check("t5_opcode", opcode, 0);
        check("t5_busy",   rx_busy, 0);
        check("t5_done",   rx_done, 0);
        instr_ready = 1'b1;
        send_frame(8'h5A, 8'h01, 4'h7, 1'b0, 1'b0);
        check("t5_op_a_new",   op_a, 8'h5A);
        check("t5_op_b_new",   op_b, 8'h01);
        check("t5_opcode_new", opcode, 4'h7);
        check("t5_valid_new",  instr_valid, 1);
        end_window();

`ifdef RX_CHECKSUM_EN
        // Nibbles 1,2,3,4,5 XOR to 1.
        send_frame(8'h21, 8'h43, 4'h5, 1'b0, 1'b0);
        check("t6_good_valid", instr_valid, 1);
        check("t6_good_op_a",  op_a, 8'h21);
        check("t6_good_op_b",  op_b, 8'h43);
        check("t6_good_chk",   rx_chk_err, 0);
        end_window();
        check("t6_good_clr", instr_valid, 0);
        send_frame(8'h21, 8'h43, 4'h5, 1'b0, 1'b1);
        check("t6_bad_chk",     rx_chk_err, 1);
        check("t6_bad_valid",   instr_valid, 0);
        check("t6_bad_done",    rx_done, 0);
        check("t6_bad_overrun", rx_overrun, 0);
        end_window();
        check("t6_chk_pulse", rx_chk_err, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
